trace_commit_serializer: RTL and testbench

- Merges the per-cycle multi-lane commit stream of the superscalar core into one in-order, one-record-per-cycle stream for the single-port trace logger.
- Sits between the ROB/commit stage and the tracer.
- Buffers bursts in a FIFO and applies backpressure when space runs low.
- Counts records lost to overflow so that a gap in the trace is detectable.

---
 rtl/trace_pkg.sv | 69 ++++++
 rtl/trace_lane_compact.sv | 32 +++
 rtl/trace_commit_serializer.sv | 132 +++++++++++++
 tb/tb_trace_commit_serializer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the commit-trace path: record width, field offsets
// in record order (pc at bit 0 upward) and field-extract helpers. The tracer
// uses the same helpers, so producer and consumer cannot disagree on layout.
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam int TRACE_REC_W   = 202;

    localparam int PC_LSB        = 0;
    localparam int INSTR_LSB     = 32;
    localparam int REG_ADDR_LSB  = 64;
    localparam int REG_DATA_LSB  = 69;
    localparam int IS_LOAD_BIT   = 101;
    localparam int IS_STORE_BIT  = 102;
    localparam int IS_FLOAT_BIT  = 103;
    localparam int MEM_SIZE_LSB  = 104;
    localparam int MEM_ADDR_LSB  = 106;
    localparam int MEM_DATA_LSB  = 138;
    localparam int FPU_FLAGS_LSB = 170;

    typedef logic [TRACE_REC_W-1:0] trace_rec_t;

    function automatic logic [31:0] rec_pc(input trace_rec_t r);
        return r[PC_LSB +: 32];
    endfunction

    function automatic logic [31:0] rec_instr(input trace_rec_t r);
        return r[INSTR_LSB +: 32];
    endfunction

    function automatic logic [4:0] rec_reg_addr(input trace_rec_t r);
        return r[REG_ADDR_LSB +: 5];
    endfunction

    function automatic logic [31:0] rec_reg_data(input trace_rec_t r);
        return r[REG_DATA_LSB +: 32];
    endfunction

    function automatic logic rec_is_load(input trace_rec_t r);
        return r[IS_LOAD_BIT];
    endfunction

    function automatic logic rec_is_store(input trace_rec_t r);
        return r[IS_STORE_BIT];
    endfunction

    function automatic logic rec_is_float(input trace_rec_t r);
        return r[IS_FLOAT_BIT];
    endfunction

    function automatic logic [1:0] rec_mem_size(input trace_rec_t r);
        return r[MEM_SIZE_LSB +: 2];
    endfunction

    function automatic logic [31:0] rec_mem_addr(input trace_rec_t r);
        return r[MEM_ADDR_LSB +: 32];
    endfunction

    function automatic logic [31:0] rec_mem_data(input trace_rec_t r);
        return r[MEM_DATA_LSB +: 32];
    endfunction

    function automatic logic [31:0] rec_fpu_flags(input trace_rec_t r);
        return r[FPU_FLAGS_LSB +: 32];
    endfunction

endpackage

// File: rtl/trace_lane_compact.sv
// -----------------------------------------------------------------------------
// trace_lane_compact
// Combinational lane compaction: counts the valid lanes and gives each lane
// its slot offset (number of valid lanes below it), so that sparse masks such
// as 101 land in consecutive FIFO slots.
// Ports:
//   valid_i  : per-lane commit valid (lane 0 oldest)
//   count_o  : popcount of valid_i
//   offset_o : per-lane write offset relative to the write pointer
// -----------------------------------------------------------------------------
module trace_lane_compact #(
    parameter int N_LANES = 3
) (
    input  logic [N_LANES-1:0]                              valid_i,
    output logic [$clog2(N_LANES+1)-1:0]                    count_o,
    output logic [N_LANES-1:0][$clog2(N_LANES+1)-1:0]       offset_o
);

    localparam int P_W = $clog2(N_LANES+1);

    always_comb begin
        logic [P_W-1:0] run;
        run      = '0;
        offset_o = '0;
        for (int k = 0; k < N_LANES; k++) begin
            offset_o[k] = run;
            run         = run + P_W'(valid_i[k]);
        end
        count_o = run;
    end

endmodule

// File: rtl/trace_commit_serializer.sv
// -----------------------------------------------------------------------------
// trace_commit_serializer
// Merges the multi-lane commit stream into one in-order record per cycle for
// the trace logger. Commit groups are buffered in a FIFO; a group that does
// not fit is dropped whole and accounted in a sticky flag and a saturating
// drop counter.
// Ports:
//   clk_i, reset_i     : clock, synchronous active-high reset
//   trace_en_i         : capture enable (low: commits ignored, FIFO drains)
//   commit_valid_i/rec : per-lane commit inputs, lane k at bits [k*W +: W]
//   commit_ready_o     : advisory, a full group of N_LANES fits
//   trace_valid_o/rec  : head of FIFO, trace_ready_i pops it
//   occupancy_o        : current entry count
//   overflow_o         : sticky group-dropped flag
//   drop_cnt_o         : saturating count of dropped records
// -----------------------------------------------------------------------------
module trace_commit_serializer
    import trace_pkg::*;
#(
    parameter int N_LANES = 3,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           trace_en_i,
    input  logic [N_LANES-1:0]             commit_valid_i,
    input  logic [N_LANES*TRACE_REC_W-1:0] commit_rec_i,
    output logic                           commit_ready_o,
    output logic                           trace_valid_o,
    output logic [TRACE_REC_W-1:0]         trace_rec_o,
    input  logic                           trace_ready_i,
    output logic [$clog2(DEPTH):0]         occupancy_o,
    output logic                           overflow_o,
    output logic [CNT_W-1:0]               drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int P_W   = $clog2(N_LANES+1);

    if (DEPTH < N_LANES || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("trace_commit_serializer: DEPTH must be a power of 2 and >= N_LANES");
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [P_W-1:0]   b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    trace_rec_t       storage_q [DEPTH];

    logic [P_W-1:0]                    p_cnt;
    logic [N_LANES-1:0][P_W-1:0]       lane_off;
    logic [N_LANES-1:0][PTR_W-1:0]     lane_addr;
    logic [N_LANES-1:0]                lane_we;
    trace_rec_t                        lane_rec [N_LANES];
    logic [OCC_W-1:0]                  free_slots;
    logic                              push_ok;
    logic                              drop;
    logic                              pop;

    trace_lane_compact #(
        .N_LANES (N_LANES)
    ) u_compact (
        .valid_i  (commit_valid_i),
        .count_o  (p_cnt),
        .offset_o (lane_off)
    );

    always_comb begin
        // Free space uses registered occupancy only: a same-cycle pop never
        // makes room for the same-cycle push.
        free_slots = OCC_W'(DEPTH) - occ_q;
        push_ok    = trace_en_i && (OCC_W'(p_cnt) <= free_slots);
        drop       = trace_en_i && (OCC_W'(p_cnt) >  free_slots);
        pop        = (occ_q != '0) && trace_ready_i;

        for (int k = 0; k < N_LANES; k++) begin
            lane_rec[k]  = commit_rec_i[k*TRACE_REC_W +: TRACE_REC_W];
            lane_addr[k] = wr_ptr_q + PTR_W'(lane_off[k]);
            lane_we[k]   = push_ok && commit_valid_i[k] && !reset_i;
        end

        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(p_cnt) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d      = occ_q + (push_ok ? OCC_W'(p_cnt) : '0) - OCC_W'(pop);
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop ? sat_add(drop_cnt_q, p_cnt) : drop_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_LANES; k++) begin
            if (lane_we[k]) begin
                storage_q[lane_addr[k]] <= lane_rec[k];
            end
        end
    end

    assign commit_ready_o = (free_slots >= OCC_W'(N_LANES));
    assign trace_valid_o  = (occ_q != '0);
    assign trace_rec_o    = storage_q[rd_ptr_q];
    assign occupancy_o    = occ_q;
    assign overflow_o     = overflow_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_trace_commit_serializer.sv
// -----------------------------------------------------------------------------
// tb_trace_commit_serializer
// Directed bench for trace_commit_serializer with DEPTH=8, N_LANES=3.
// -----------------------------------------------------------------------------
module tb_trace_commit_serializer;
    import trace_pkg::*;

    localparam int N_LANES = 3;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;

    logic                           clk_i = 1'b0;
    logic                           reset_i;
    logic                           trace_en_i;
    logic [N_LANES-1:0]             commit_valid_i;
    logic [N_LANES*TRACE_REC_W-1:0] commit_rec_i;
    logic                           commit_ready_o;
    logic                           trace_valid_o;
    logic [TRACE_REC_W-1:0]         trace_rec_o;
    logic                           trace_ready_i;
    logic [$clog2(DEPTH):0]         occupancy_o;
    logic                           overflow_o;
    logic [CNT_W-1:0]               drop_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    trace_commit_serializer #(
        .N_LANES (N_LANES),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .trace_en_i     (trace_en_i),
        .commit_valid_i (commit_valid_i),
        .commit_rec_i   (commit_rec_i),
        .commit_ready_o (commit_ready_o),
        .trace_valid_o  (trace_valid_o),
        .trace_rec_o    (trace_rec_o),
        .trace_ready_i  (trace_ready_i),
        .occupancy_o    (occupancy_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic trace_rec_t mk(input logic [31:0] pc);
        trace_rec_t r;
        r = '0;
        r[PC_LSB +: 32]       = pc;
        r[INSTR_LSB +: 32]    = pc ^ 32'hdead_beef;
        r[MEM_ADDR_LSB +: 32] = pc + 32'h40;
        r[IS_LOAD_BIT]        = pc[2];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int k, input logic [31:0] pc);
        commit_rec_i[k*TRACE_REC_W +: TRACE_REC_W] = mk(pc);
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] pc);
        chk(tag, 256'(rec_pc(trace_rec_o)), 256'(pc));
    endtask

    initial begin
        logic [31:0] exp_q [$];

        reset_i        = 1'b1;
        trace_en_i     = 1'b0;
        commit_valid_i = '0;
        commit_rec_i   = '0;
        trace_ready_i  = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk("rst_occ",   256'(occupancy_o),    256'(0));
        chk("rst_valid", 256'(trace_valid_o),  256'(0));
        chk("rst_ready", 256'(commit_ready_o), 256'(1));
        chk("rst_ovf",   256'(overflow_o),     256'(0));
        chk("rst_drop",  256'(drop_cnt_o),     256'(0));

        // 1: single lane, one-cycle latency
        trace_en_i     = 1'b1;
        trace_ready_i  = 1'b1;
        commit_valid_i = 3'b001;
        set_lane(0, 32'h8000_0000);
        tick();
        commit_valid_i = '0;
        chk("t1_valid", 256'(trace_valid_o), 256'(1));
        chk_pc("t1_pc", 32'h8000_0000);
        chk("t1_rec", 256'(trace_rec_o), 256'(mk(32'h8000_0000)));
        chk("t1_occ1", 256'(occupancy_o), 256'(1));
        tick();
        chk("t1_occ0", 256'(occupancy_o), 256'(0));
        chk("t1_empty", 256'(trace_valid_o), 256'(0));

        // 2: sparse mask compaction
        commit_valid_i = 3'b101;
        set_lane(0, 32'h100);
        set_lane(1, 32'hbad);
        set_lane(2, 32'h108);
        tick();
        commit_valid_i = '0;
        chk_pc("t2_pc0", 32'h100);
        chk("t2_occ2", 256'(occupancy_o), 256'(2));
        tick();
        chk_pc("t2_pc1", 32'h108);
        chk("t2_valid", 256'(trace_valid_o), 256'(1));
        chk("t2_occ1", 256'(occupancy_o), 256'(1));
        tick();
        chk("t2_occ0", 256'(occupancy_o), 256'(0));

        // 3: fill, whole-group drop, partial group still fits
        trace_ready_i  = 1'b0;
        commit_valid_i = 3'b111;
        set_lane(0, 32'h200); set_lane(1, 32'h204); set_lane(2, 32'h208);
        tick();
        set_lane(0, 32'h20c); set_lane(1, 32'h210); set_lane(2, 32'h214);
        tick();
        commit_valid_i = '0;
        chk("t3_occ6", 256'(occupancy_o), 256'(6));
        chk("t3_ready0", 256'(commit_ready_o), 256'(0));
        chk("t3_ovf0", 256'(overflow_o), 256'(0));
        commit_valid_i = 3'b111;
        set_lane(0, 32'h300); set_lane(1, 32'h304); set_lane(2, 32'h308);
        tick();
        commit_valid_i = '0;
        chk("t3_occ_drop", 256'(occupancy_o), 256'(6));
        chk("t3_drop3", 256'(drop_cnt_o), 256'(3));
        chk("t3_ovf1", 256'(overflow_o), 256'(1));
        commit_valid_i = 3'b011;
        set_lane(0, 32'h400); set_lane(1, 32'h404);
        tick();
        commit_valid_i = '0;
        chk("t3_occ8", 256'(occupancy_o), 256'(8));
        chk("t3_drop_keep", 256'(drop_cnt_o), 256'(3));
        chk_pc("t3_hold", 32'h200);
        tick();
        chk_pc("t3_hold2", 32'h200);
        exp_q = '{32'h200, 32'h204, 32'h208, 32'h20c, 32'h210, 32'h214, 32'h400, 32'h404};
        trace_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_pc($sformatf("t3_drain%0d", i), exp_q[i]);
            tick();
        end
        chk("t3_empty", 256'(occupancy_o), 256'(0));

        // 4: push and pop in the same cycle, then pointer wrap
        trace_ready_i  = 1'b0;
        commit_valid_i = 3'b111;
        set_lane(0, 32'h500); set_lane(1, 32'h504); set_lane(2, 32'h508);
        tick();
        commit_valid_i = 3'b011;
        set_lane(0, 32'h50c); set_lane(1, 32'h510);
        tick();
        commit_valid_i = '0;
        chk("t4_occ5", 256'(occupancy_o), 256'(5));
        trace_ready_i  = 1'b1;
        commit_valid_i = 3'b111;
        set_lane(0, 32'h514); set_lane(1, 32'h518); set_lane(2, 32'h51c);
        tick();
        commit_valid_i = '0;
        trace_ready_i  = 1'b0;
        chk("t4_occ7", 256'(occupancy_o), 256'(7));
        trace_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk_pc($sformatf("t4_drain%0d", i), 32'h504 + 32'(4*i));
            tick();
        end
        chk("t4_empty", 256'(occupancy_o), 256'(0));
        for (int i = 0; i < 40; i++) begin
            commit_valid_i = 3'b001;
            set_lane(0, 32'h1000 + 32'(4*i));
            tick();
            chk_pc($sformatf("t4_wrap%0d", i), 32'h1000 + 32'(4*i));
            chk($sformatf("t4_wocc%0d", i), 256'(occupancy_o), 256'(1));
        end
        commit_valid_i = '0;
        tick();
        chk("t4_wrap_empty", 256'(occupancy_o), 256'(0));

        // 5: capture disabled
        reset_i = 1'b1;
        tick();
        reset_i        = 1'b0;
        trace_ready_i  = 1'b0;
        commit_valid_i = 3'b011;
        set_lane(0, 32'h600); set_lane(1, 32'h604);
        tick();
        trace_en_i     = 1'b0;
        commit_valid_i = 3'b111;
        set_lane(0, 32'h700); set_lane(1, 32'h704); set_lane(2, 32'h708);
        tick();
        chk("t5_occ_a", 256'(occupancy_o), 256'(2));
        chk("t5_drop_a", 256'(drop_cnt_o), 256'(0));
        tick();
        chk("t5_occ_b", 256'(occupancy_o), 256'(2));
        trace_ready_i = 1'b1;
        tick();
        chk("t5_occ_c", 256'(occupancy_o), 256'(1));
        chk_pc("t5_pc", 32'h604);
        tick();
        chk("t5_occ_d", 256'(occupancy_o), 256'(0));
        chk("t5_drop_d", 256'(drop_cnt_o), 256'(0));
        chk("t5_ovf_d", 256'(overflow_o), 256'(0));
        commit_valid_i = '0;
        trace_en_i     = 1'b1;

        // 6: reset mid-operation beats a same-cycle push and pop
        trace_ready_i  = 1'b0;
        commit_valid_i = 3'b111;
        set_lane(0, 32'h800); set_lane(1, 32'h804); set_lane(2, 32'h808);
        tick();
        tick();
        commit_valid_i = 3'b011;
        tick();
        commit_valid_i = 3'b001;
        tick();
        commit_valid_i = '0;
        chk("t6_drop1", 256'(drop_cnt_o), 256'(1));
        trace_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        trace_ready_i = 1'b0;
        chk("t6_occ4", 256'(occupancy_o), 256'(4));
        chk("t6_ovf1", 256'(overflow_o), 256'(1));
        reset_i        = 1'b1;
        commit_valid_i = 3'b111;
        trace_ready_i  = 1'b1;
        tick();
        reset_i        = 1'b0;
        commit_valid_i = '0;
        chk("t6_valid", 256'(trace_valid_o), 256'(0));
        chk("t6_occ", 256'(occupancy_o), 256'(0));
        chk("t6_ovf", 256'(overflow_o), 256'(0));
        chk("t6_drop", 256'(drop_cnt_o), 256'(0));
        chk("t6_ready", 256'(commit_ready_o), 256'(1));
        tick();
        chk("t6_occ_after", 256'(occupancy_o), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
